// File: rtl/quad_pkg.sv
// Shared constants for the quadrature decoder: Gray states, FSM encoding, direction.
package quad_pkg;

   localparam logic [1:0] S00 = 2'b00;
   localparam logic [1:0] S10 = 2'b10;
   localparam logic [1:0] S11 = 2'b11;
   localparam logic [1:0] S01 = 2'b01;

   localparam logic [0:0] ST_INIT  = 1'b0;
   localparam logic [0:0] ST_TRACK = 1'b1;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // Forward successor of a {A,B} Gray state: 00->10->11->01->00.
   function automatic logic [1:0] quad_fwd(input logic [1:0] s);
      logic [1:0] n;
      case (s)
         S00:     n = S10;
         S10:     n = S11;
         S11:     n = S01;
         default: n = S00;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder phases, control and decoded outputs of quad_decoder.
interface quad_decoder_if #(parameter int DATAWIDTH = 16);
   logic                 a_in;
   logic                 b_in;
   logic                 idx_in;
   logic                 idx_clr_en;
   logic                 load;
   logic [DATAWIDTH-1:0] load_value;
   logic                 step;
   logic                 down;
   logic                 err;
   logic                 err_flag;
   logic                 idx_pulse;
   logic [DATAWIDTH-1:0] pos;

   modport master (
      output a_in, b_in, idx_in, idx_clr_en, load, load_value,
      input  step, down, err, err_flag, idx_pulse, pos
   );

   modport slave (
      input  a_in, b_in, idx_in, idx_clr_en, load, load_value,
      output step, down, err, err_flag, idx_pulse, pos
   );
endinterface

// File: rtl/quad_sync.sv
// Per-input synchronizer; with QUAD_GLITCH_FILTER_EN defined, adds a 3-sample
// stability filter that contributes 2 cycles of latency.
module quad_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
   end

`ifdef QUAD_GLITCH_FILTER_EN
   logic [1:0] r_hist;
   logic       r_filt;
   logic       w_s;
   logic       w_stable;

   assign w_s      = r_sync[SYNC_STAGES-1];
   assign w_stable = (w_s == r_hist[0]) && (w_s == r_hist[1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hist <= '0;
         r_filt <= 1'b0;
      end else begin
         r_hist <= {r_hist[0], w_s};
         if (w_stable) r_filt <= w_s;
      end
   end

   // Pass the third matching sample straight through so the filter costs 2 cycles, not 3.
   assign o_q = w_stable ? w_s : r_filt;
`else
   assign o_q = r_sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: x4 step/direction, illegal-edge detection, index qualifier
// and wrap-around position register. Optional input filter: QUAD_GLITCH_FILTER_EN.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int                   DATAWIDTH   = 16,
   parameter int                   SYNC_STAGES = 2,
   parameter logic [DATAWIDTH-1:0] START       = '0
) (
   input  logic           clk,
   input  logic           rst,
   quad_decoder_if.slave  bus
);

`ifdef QUAD_GLITCH_FILTER_EN
   localparam int FILL = SYNC_STAGES + 1;
`else
   localparam int FILL = SYNC_STAGES - 1;
`endif

   logic [2:0]           w_raw;
   logic [2:0]           w_syn;
   logic [1:0]           w_ab;
   logic                 w_si;
   logic                 w_up;
   logic                 w_dn;
   logic                 w_bad;
   logic                 w_idx;

   logic [0:0]           r_state;
   logic [1:0]           r_prev;
   logic                 r_si_prev;
   logic [FILL:0]        r_vld_pipe;
   logic                 r_step;
   logic                 r_down;
   logic                 r_err;
   logic                 r_err_flag;
   logic                 r_idx_pulse;
   logic [DATAWIDTH-1:0] r_pos;

   assign w_raw = {bus.a_in, bus.b_in, bus.idx_in};

   for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      quad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk (clk),
         .rst (rst),
         .i_d (w_raw[gi]),
         .o_q (w_syn[gi])
      );
   end

   assign w_ab = w_syn[2:1];
   assign w_si = w_syn[0];

   always_comb begin
      w_up  = 1'b0;
      w_dn  = 1'b0;
      w_bad = 1'b0;
      if (r_state == ST_TRACK && w_ab != r_prev) begin
         if (w_ab == quad_fwd(r_prev))      w_up  = 1'b1;
         else if (r_prev == quad_fwd(w_ab)) w_dn  = 1'b1;
         else                               w_bad = 1'b1;
      end
   end

   assign w_idx = (r_state == ST_TRACK) && w_si && !r_si_prev && (w_ab == S11);

   // INIT waits until the synchronizer holds post-reset samples, so the reset
   // zeros are never compared against real encoder levels.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_prev      <= S00;
         r_si_prev   <= 1'b0;
         r_vld_pipe  <= '0;
         r_step      <= 1'b0;
         r_down      <= DIR_UP;
         r_err       <= 1'b0;
         r_err_flag  <= 1'b0;
         r_idx_pulse <= 1'b0;
         r_pos       <= START;
      end else begin
         r_vld_pipe  <= {r_vld_pipe[FILL-1:0], 1'b1};
         r_si_prev   <= w_si;
         r_step      <= w_up | w_dn;
         r_down      <= w_dn ? DIR_DOWN : DIR_UP;
         r_err       <= w_bad;
         r_idx_pulse <= w_idx;

         case (r_state)
            ST_INIT: begin
               if (r_vld_pipe[FILL]) begin
                  r_prev  <= w_ab;
                  r_state <= ST_TRACK;
               end
            end
            default: r_prev <= w_ab;
         endcase

         if (w_bad)         r_err_flag <= 1'b1;
         else if (bus.load) r_err_flag <= 1'b0;

         if (bus.load)                    r_pos <= bus.load_value;
         else if (w_idx && bus.idx_clr_en) r_pos <= START;
         else if (w_up)                   r_pos <= r_pos + 1'b1;
         else if (w_dn)                   r_pos <= r_pos - 1'b1;
      end
   end

   assign bus.step      = r_step;
   assign bus.down      = r_down;
   assign bus.err       = r_err;
   assign bus.err_flag  = r_err_flag;
   assign bus.idx_pulse = r_idx_pulse;
   assign bus.pos       = r_pos;

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder with an integrated position register. It converts asynchronous A/B/index encoder phases into per-edge step/direction pulses and a signed-agnostic, wrap-around position count. Its step/down outputs use the same command semantics as the team's up/down load counter, so it can drive that counter directly or be used standalone through its own `pos` register.

## Interface
Parameters:
- `DATAWIDTH`, 16: width of `pos` and `load_value`.
- `SYNC_STAGES`, 2: synchronizer flops per input; legal range 2..4.
- `START`, 0: reset and index-clear value of `pos`.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `a_in`, in, 1: encoder phase A, asynchronous.
- `b_in`, in, 1: encoder phase B, asynchronous.
- `idx_in`, in, 1: encoder index, asynchronous.
- `idx_clr_en`, in, 1: when high, a qualified index event loads `START` into `pos`.
- `load`, in, 1: synchronous load of `pos`; also clears `err_flag`.
- `load_value`, in, DATAWIDTH: value loaded on `load`.
- `step`, out, 1: one-cycle pulse per valid quadrature edge.
- `down`, out, 1: direction of the current `step` (1 = reverse); valid only while `step` = 1.
- `err`, out, 1: one-cycle pulse on an illegal transition.
- `err_flag`, out, 1: sticky error flag.
- `idx_pulse`, out, 1: one-cycle pulse on a qualified index event.
- `pos`, out, DATAWIDTH: position count.

## Operation
- Each input passes through `SYNC_STAGES` flops. Decoding uses only the synchronized values `sa`, `sb`, `si`.
- The FSM has two states, INIT and TRACK.
  - INIT is entered on `rst`. In INIT the FSM captures {sa,sb} into `prev` and decodes nothing, then moves to TRACK.
  - TRACK compares the current {sa,sb} against `prev` every cycle and updates `prev`.
- Forward (up) sequence: 00→10→11→01→00. Any single-bit change along this sequence gives `step` = 1, `down` = 0.
- Reverse sequence: 00→01→11→10→00. Any single-bit change along this sequence gives `step` = 1, `down` = 1.
- No change: no pulse.
- Both bits changing is illegal: `err` = 1, `err_flag` is set, and there is no step. `prev` still updates to the new value.
- Counting is x4: every valid edge moves `pos` by ±1.
- `pos` arithmetic is modulo 2^DATAWIDTH. At the boundaries: all-ones + 1 → 0, and 0 − 1 → all-ones. No saturation and no overflow flag.
- Index qualification: a rising edge of `si` while {sa,sb} = 11 produces `idx_pulse`. If `idx_clr_en` is also high, `pos` is loaded with `START`.
- Priority of `pos` updates in one cycle: `load` > index clear > step. Discarded steps still produce `step`/`down` pulses.
- `load` and a same-cycle illegal transition: `err` pulses and `err_flag` ends the cycle at 1 (set wins over clear).

## Timing
- Reset values: `pos` = START, `step` = 0, `down` = 0, `err` = 0, `err_flag` = 0, `idx_pulse` = 0, state = INIT, all synchronizer flops = 0.
- After `rst` deasserts:
  - the first cycle is spent in INIT;
  - no `step` or `err` can occur until the second cycle.
- Latency from an input edge to `step`/`err`/`idx_pulse` is `SYNC_STAGES` + 1 cycles (3 at default). `pos` reflects the edge in the same cycle that `step` is high.
- `load` takes effect on the next rising edge.
- `rst` asserted mid-sequence overrides everything in that cycle and returns the block to INIT.
- Inputs must stay stable for at least 1 clock per Gray state. Faster input is reported as `err`, not miscounted silently.
- All outputs are registered.

## Configuration
- `QUAD_GLITCH_FILTER_EN`
  - Defined: after synchronization, each of `sa`/`sb`/`si` passes through a stability filter that accepts a new level only after 3 consecutive identical samples. This adds 2 cycles of latency (total `SYNC_STAGES` + 3) and raises the minimum stable time to 3 clocks per state.
  - Undefined: no filter; timing is as stated above.

## Structure
- Package `quad_pkg`:
  - localparams for Gray states (S00, S10, S11, S01);
  - FSM state encoding (INIT, TRACK);
  - direction constants (DIR_UP = 0, DIR_DOWN = 1).
- Sub-module `quad_sync`: one per input, holding the `SYNC_STAGES` synchronizer and, under `QUAD_GLITCH_FILTER_EN`, the stability filter.
- The decoder FSM, index qualifier and position register live in `quad_decoder`.

## Test plan
- Reset: hold A/B = 11 through reset, then release and hold. Expect no `err`, no `step`, and `pos` = 0.
- Forward/reverse: 8 forward edges from 00, then 3 reverse edges, each state held 4 clocks. Expect 8 `step` with `down` = 0 and `pos` = 8, then 3 `step` with `down` = 1 and `pos` = 5. Each `step` appears 3 cycles after its input edge.
- Wrap: `load` 16'hFFFF, then 1 forward edge, then 2 reverse edges. Expect `pos` = 0, then 16'hFFFF, then 16'hFFFE.
- Illegal edge: jump A/B 00→11. Expect a one-cycle `err`, `err_flag` = 1 and `pos` unchanged. A later `load` clears `err_flag`.
- Index: `idx_clr_en` = 1, `pos` = 37, index rises while A/B = 11. Expect `idx_pulse` and `pos` = START. The same index event at A/B = 01 produces no pulse.
- Priority: `load` of 100 coincident with a forward step and a qualified index event. Expect `pos` = 100 while `step` and `idx_pulse` still pulse.
